// File: rtl/seg7_pkg.sv
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared seven-segment types, hex pattern table and polarity helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF_AH = 7'h00;

   // Active-high gfedcba patterns, entry n is hex digit n.
   localparam logic [15:0][6:0] SEG_PAT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic seg_t to_pol(input seg_t pattern, input logic active_low);
      return active_low ? ~pattern : pattern;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hex_to_seg7.sv
// ============================================================================
// Module  : hex_to_seg7
// Purpose : Nibble + blank + dp to seven-segment decoder with output polarity.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_seg7
   import seg7_pkg::*;
#(
   parameter int ACTIVE_LOW = 1
) (
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   input  logic       dp_i,
   output logic [6:0] seg_o,
   output logic       dp_o
);

   localparam logic POL = (ACTIVE_LOW != 0);

   seg_t seg_ah;
   logic dp_ah;

   always_comb begin
      seg_ah = blank_i ? SEG_OFF_AH : SEG_PAT[nibble_i];
      dp_ah  = dp_i & ~blank_i;
   end

   assign seg_o = to_pol(seg_ah, POL);
   assign dp_o  = POL ? ~dp_ah : dp_ah;

endmodule

`default_nettype wire

// File: rtl/seg7_scan_display.sv
// ============================================================================
// Module  : seg7_scan_display
// Purpose : Shadowed N-digit hex display driving static and scanned segments.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_DIV    = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic                    load_i,
   input  logic                    freeze_i,
   input  logic                    blank_lz_i,
   input  logic [NUM_DIGITS-1:0]   dp_in_i,
   output logic [7*NUM_DIGITS-1:0] hex_out_o,
   output logic [NUM_DIGITS-1:0]   dp_out_o,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o
);

   localparam int   IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int   PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic POL     = (ACTIVE_LOW != 0);
   localparam seg_t SEG_OFF = to_pol(SEG_OFF_AH, POL);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = POL ? '1 : '0;

   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]   dp_reg_q, dp_reg_d;
   logic [PS_W-1:0]         ps_q, ps_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    live_q;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic                    tick;
   logic                    upper_zero;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [NUM_DIGITS-1:0]   static_blank;
   logic [NUM_DIGITS-1:0]   an_ah;
   logic [3:0]              scan_nib;
   logic                    scan_blank;
   logic                    scan_dp;

   always_comb begin
      shadow_d = shadow_q;
      dp_reg_d = dp_reg_q;
      if (load_i && !freeze_i) begin
         shadow_d = value_i;
         dp_reg_d = dp_in_i;
      end
   end

   always_comb begin
      tick  = (ps_q == PS_W'(CLK_DIV - 1));
      ps_d  = tick ? '0 : ps_q + 1'b1;
      idx_d = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // Walk from the top digit down; a digit blanks only if it and all above are zero.
   always_comb begin
      upper_zero = 1'b1;
      blank_mask = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (shadow_q[4*i +: 4] == 4'h0);
         if (i != 0) begin
            blank_mask[i] = blank_lz_i & upper_zero;
         end
      end
   end

   // Static outputs read as off until the first edge after reset releases.
   assign static_blank = blank_mask | {NUM_DIGITS{~live_q}};

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_static
      hex_to_seg7 #(
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_dec (
         .nibble_i (shadow_q[4*g +: 4]),
         .blank_i  (static_blank[g]),
         .dp_i     (dp_reg_q[g]),
         .seg_o    (hex_out_o[7*g +: 7]),
         .dp_o     (dp_out_o[g])
      );
   end

   always_comb begin
      scan_nib   = 4'h0;
      scan_blank = 1'b0;
      scan_dp    = 1'b0;
      an_ah      = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            scan_nib   = shadow_q[4*i +: 4];
            scan_blank = blank_mask[i];
            scan_dp    = dp_reg_q[i];
            an_ah[i]   = ~blank_mask[i];
         end
      end
      an_d = POL ? ~an_ah : an_ah;
   end

   hex_to_seg7 #(
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_scan_dec (
      .nibble_i (scan_nib),
      .blank_i  (scan_blank),
      .dp_i     (scan_dp),
      .seg_o    (seg_d),
      .dp_o     (dp_d)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= '0;
         dp_reg_q <= '0;
         ps_q     <= '0;
         idx_q    <= '0;
         live_q   <= 1'b0;
         seg_q    <= SEG_OFF;
         dp_q     <= POL;
         an_q     <= AN_OFF;
      end else begin
         shadow_q <= shadow_d;
         dp_reg_q <= dp_reg_d;
         ps_q     <= ps_d;
         idx_q    <= idx_d;
         live_q   <= 1'b1;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
      end
   end

   assign seg_o = seg_q;
   assign dp_o  = dp_q;
   assign an_o  = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
// ============================================================================
// Module  : tb_seg7_scan_display
// Purpose : Directed table-driven bench for seg7_scan_display (8 digits, /4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_display;

   typedef struct {
      logic [31:0] value;
      logic [7:0]  dp;
      logic        blz;
      logic [55:0] hex;
      logic [7:0]  dpo;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] value;
   logic        load;
   logic        freeze;
   logic        blz;
   logic [7:0]  dp_in;
   logic [55:0] hex_out;
   logic [7:0]  dp_out;
   logic [6:0]  seg;
   logic        dp;
   logic [7:0]  an;

   int tests = 0;
   int fails = 0;
   vec_t vecs[7];

   always #5 clk = ~clk;

   seg7_scan_display #(
      .NUM_DIGITS (8),
      .CLK_DIV    (4),
      .ACTIVE_LOW (1)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .value_i    (value),
      .load_i     (load),
      .freeze_i   (freeze),
      .blank_lz_i (blz),
      .dp_in_i    (dp_in),
      .hex_out_o  (hex_out),
      .dp_out_o   (dp_out),
      .seg_o      (seg),
      .dp_o       (dp),
      .an_o       (an)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_an(input logic [7:0] target, input bit equal, input string name);
      int n = 0;
      while (((an == target) != equal) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) begin
         tests++;
         fails++;
         $display("FAIL %s: timeout, an=%0h target=%0h", name, an, target);
      end
   endtask

   task automatic load_word(input logic [31:0] v, input logic [7:0] d, input logic b);
      value = v;
      dp_in = d;
      blz   = b;
      load  = 1'b1;
      step();
      load  = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_an;
      logic [7:0] a0;
      int cnt_ff, multi, bad, other;
      bit changed;

      vecs[0] = '{32'h1234ABCD, 8'h00, 1'b0,
                  {7'h79,7'h24,7'h30,7'h19,7'h08,7'h03,7'h46,7'h21}, 8'hFF};
      vecs[1] = '{32'h000000A0, 8'h00, 1'b1,
                  {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h08,7'h40}, 8'hFF};
      vecs[2] = '{32'h00000000, 8'hFF, 1'b1,
                  {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 8'hFE};
      vecs[3] = '{32'h00000000, 8'h0F, 1'b0,
                  {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 8'hF0};
      vecs[4] = '{32'h00F00000, 8'h81, 1'b1,
                  {7'h7F,7'h7F,7'h0E,7'h40,7'h40,7'h40,7'h40,7'h40}, 8'hFE};
      vecs[5] = '{32'h89ABCDEF, 8'hAA, 1'b1,
                  {7'h00,7'h10,7'h08,7'h03,7'h46,7'h21,7'h06,7'h0E}, 8'h55};
      vecs[6] = '{32'h10000000, 8'h00, 1'b1,
                  {7'h79,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 8'hFF};

      value = '0; load = 1'b0; freeze = 1'b0; blz = 1'b0; dp_in = '0;

      // Reset asserted before any clock edge.
      #1 rst_n = 1'b0;
      #1;
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_an", an, 8'hFF);
      chk("rst_hex", hex_out, {56{1'b1}});
      chk("rst_dpout", dp_out, 8'hFF);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_an", an, 8'hFF);
      chk("rst_hold_hex", hex_out, {56{1'b1}});
      rst_n = 1'b1;
      step();

      for (int v = 0; v < 7; v++) begin
         load_word(vecs[v].value, vecs[v].dp, vecs[v].blz);
         chk($sformatf("vec%0d_hex", v), hex_out, vecs[v].hex);
         chk($sformatf("vec%0d_dpout", v), dp_out, vecs[v].dpo);
      end

      // Full scan rotation of 1234ABCD, 4 cycles per slot.
      load_word(32'h1234ABCD, 8'h00, 1'b0);
      step();
      wait_an(8'hFE, 1'b0, "scan_sync_leave");
      wait_an(8'hFE, 1'b1, "scan_sync_enter");
      for (int k = 0; k < 8; k++) begin
         exp_an = ~(8'h01 << k);
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("scan_an_d%0d_c%0d", k, c), an, exp_an);
            chk($sformatf("scan_seg_d%0d_c%0d", k, c), seg, vecs[0].hex[7*k +: 7]);
            step();
         end
         chk($sformatf("scan_dp_d%0d", k), dp, 1'b1);
      end
      chk("scan_wrap", an, 8'hFE);

      // Leading-zero blanking in the scanned path.
      load_word(32'h000000A0, 8'h00, 1'b1);
      step();
      step();
      cnt_ff = 0; multi = 0; bad = 0; other = 0;
      for (int c = 0; c < 32; c++) begin
         if (an == 8'hFF) cnt_ff++;
         if ($countones(~an) > 1) multi++;
         if (an == 8'hFD && seg != 7'h08) bad++;
         if (an == 8'hFE && seg != 7'h40) bad++;
         if (an != 8'hFF && an != 8'hFD && an != 8'hFE) other++;
         step();
      end
      chk("blank_off_cycles", cnt_ff, 24);
      chk("blank_onehot", multi, 0);
      chk("blank_seg", bad, 0);
      chk("blank_stray_an", other, 0);

      // All-zero word with every dp requested: only digit 0 shows.
      load_word(32'h00000000, 8'hFF, 1'b1);
      wait_an(8'hFE, 1'b1, "dp_wait");
      chk("dp_seg", seg, 7'h40);
      chk("dp_lit", dp, 1'b0);

      // Freeze beats load; scanning keeps running.
      load_word(32'h00000000, 8'h00, 1'b0);
      freeze = 1'b1;
      load_word(32'hFFFFFFFF, 8'h00, 1'b0);
      chk("freeze_hex", hex_out, {8{7'h40}});
      a0 = an;
      changed = 1'b0;
      repeat (8) begin
         step();
         if (an != a0) changed = 1'b1;
      end
      chk("freeze_scanning", changed, 1'b1);
      chk("freeze_hold", hex_out, {8{7'h40}});
      freeze = 1'b0;
      load_word(32'hFFFFFFFF, 8'h00, 1'b0);
      chk("unfreeze_hex", hex_out, {8{7'h0E}});

      // Asynchronous reset mid-slot 5, then first slot timing.
      wait_an(8'hDF, 1'b1, "areset_wait");
      #2 rst_n = 1'b0;
      #1;
      chk("areset_an", an, 8'hFF);
      chk("areset_seg", seg, 7'h7F);
      chk("areset_hex", hex_out, {56{1'b1}});
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("release_an", an, 8'hFF);
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("first_slot_c%0d", c), an, 8'hFE);
      end
      step();
      chk("second_slot", an, 8'hFD);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
